// File: rtl/calibration_registers.sv
// Purpose: calibration settings with live/applied shadow pairs, committed on frame boundaries.
// Latency: step pulses reach the live registers in 1 cycle; live values are applied at the first frame_done seen in PENDING.
// Backpressure: none; every step/reset pulse is accepted in the cycle it is asserted.
module calibration_registers #(
  parameter logic [15:0] PIXEL_DEFAULT  = 16'd1024,
  parameter logic [15:0] PIXEL_STEP     = 16'd64,
  parameter logic [15:0] PIXEL_MAX      = 16'd4096,
  parameter logic [2:0]  FILTER_DEFAULT = 3'd0,
  parameter logic [2:0]  FILTER_MAX     = 3'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_pixel_add,
  input  logic        enable_pixel_sub,
  input  logic        enable_filter_add,
  input  logic        enable_filter_sub,
  input  logic        reset_pixel,
  input  logic        reset_filter,
  input  logic        frame_done,
  output logic [15:0] pixel_threshold,
  output logic [2:0]  filter_select,
  output logic        cfg_pending,
  output logic        cfg_update
);

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_PENDING = 2'd1;
  localparam logic [1:0] STATE_APPLY   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] live_pixel;
  logic [2:0]  live_filter;
  logic [15:0] live_pixel_next;
  logic [2:0]  live_filter_next;
  logic [16:0] pixel_sum;
  logic [15:0] pixel_inc;
  logic [15:0] pixel_dec;
  logic [2:0]  filter_inc;
  logic [2:0]  filter_dec;
  logic        diverged;
  logic        apply_now;

  // Saturating/wrapping step candidates; the add is 17 bits wide so it can never wrap.
  always_comb begin
    pixel_sum  = {1'b0, live_pixel} + {1'b0, PIXEL_STEP};
    pixel_inc  = (pixel_sum > {1'b0, PIXEL_MAX}) ? PIXEL_MAX : pixel_sum[15:0];
    pixel_dec  = (live_pixel < PIXEL_STEP) ? 16'd0 : (live_pixel - PIXEL_STEP);
    filter_inc = (live_filter >= FILTER_MAX) ? 3'd0 : (live_filter + 3'd1);
    filter_dec = (live_filter == 3'd0) ? FILTER_MAX : (live_filter - 3'd1);
  end

  // Next live values: restore-default wins, add and sub together cancel.
  always_comb begin
    live_pixel_next = live_pixel;
    if (reset_pixel)
      live_pixel_next = PIXEL_DEFAULT;
    else if (enable_pixel_add && !enable_pixel_sub)
      live_pixel_next = pixel_inc;
    else if (enable_pixel_sub && !enable_pixel_add)
      live_pixel_next = pixel_dec;

    live_filter_next = live_filter;
    if (reset_filter)
      live_filter_next = FILTER_DEFAULT;
    else if (enable_filter_add && !enable_filter_sub)
      live_filter_next = filter_inc;
    else if (enable_filter_sub && !enable_filter_add)
      live_filter_next = filter_dec;
  end

  // Commit decision: only registered live/applied values and state are consulted, so a
  // step landing on the frame_done edge stays pending for the following frame.
  always_comb begin
    diverged   = (live_pixel != pixel_threshold) || (live_filter != filter_select);
    apply_now  = 1'b0;
    state_next = STATE_IDLE;
    case (state)
      STATE_IDLE: begin
        state_next = diverged ? STATE_PENDING : STATE_IDLE;
      end
      STATE_PENDING: begin
        if (!diverged) begin
          state_next = STATE_IDLE;
        end else if (frame_done) begin
          apply_now  = 1'b1;
          state_next = STATE_APPLY;
        end else begin
          state_next = STATE_PENDING;
        end
      end
      STATE_APPLY: begin
        state_next = diverged ? STATE_PENDING : STATE_IDLE;
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  // Live registers track the calibration FSM pulses every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      live_pixel  <= PIXEL_DEFAULT;
      live_filter <= FILTER_DEFAULT;
    end else begin
      live_pixel  <= live_pixel_next;
      live_filter <= live_filter_next;
    end
  end

  // Applied registers and handshake state; applied only moves on a commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= STATE_IDLE;
      pixel_threshold <= PIXEL_DEFAULT;
      filter_select   <= FILTER_DEFAULT;
    end else begin
      state <= state_next;
      if (apply_now) begin
        pixel_threshold <= live_pixel;
        filter_select   <= live_filter;
      end
    end
  end

  // Status outputs are pure decodes of the registered state.
  always_comb begin
    cfg_pending = (state == STATE_PENDING);
    cfg_update  = (state == STATE_APPLY);
  end

endmodule

// File: tb/tb_calibration_registers.sv
module tb_calibration_registers;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_pixel_add = 1'b0;
  logic        enable_pixel_sub = 1'b0;
  logic        enable_filter_add = 1'b0;
  logic        enable_filter_sub = 1'b0;
  logic        reset_pixel = 1'b0;
  logic        reset_filter = 1'b0;
  logic        frame_done = 1'b0;
  logic [15:0] pixel_threshold;
  logic [2:0]  filter_select;
  logic        cfg_pending;
  logic        cfg_update;

  calibration_registers dut (
    .clock             (clock),
    .reset             (reset),
    .enable_pixel_add  (enable_pixel_add),
    .enable_pixel_sub  (enable_pixel_sub),
    .enable_filter_add (enable_filter_add),
    .enable_filter_sub (enable_filter_sub),
    .reset_pixel       (reset_pixel),
    .reset_filter      (reset_filter),
    .frame_done        (frame_done),
    .pixel_threshold   (pixel_threshold),
    .filter_select     (filter_select),
    .cfg_pending       (cfg_pending),
    .cfg_update        (cfg_update)
  );

  always #5 clock = ~clock;

  // Stimulus bit masks
  localparam int RST = 1 << 0;
  localparam int PA  = 1 << 1;
  localparam int PS  = 1 << 2;
  localparam int FA  = 1 << 3;
  localparam int FS  = 1 << 4;
  localparam int RP  = 1 << 5;
  localparam int RF  = 1 << 6;
  localparam int FD  = 1 << 7;
  localparam int IDLE = 0;

  int total = 0;
  int bad   = 0;

  // Reference model: live and applied settings as plain integers, plus the two status flags.
  int m_lp, m_lf, m_ap, m_af;
  bit m_pend, m_upd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int s);
    bit mismatch, apply;
    int old_lp, old_lf;
    if ((s & RST) != 0) begin
      m_lp = 1024; m_lf = 0; m_ap = 1024; m_af = 0; m_pend = 0; m_upd = 0;
      return;
    end
    old_lp   = m_lp;
    old_lf   = m_lf;
    mismatch = (m_lp != m_ap) || (m_lf != m_af);
    apply    = m_pend && ((s & FD) != 0) && mismatch;
    // pixel step
    if ((s & RP) != 0) m_lp = 1024;
    else if ((s & PA) != 0 && (s & PS) == 0) m_lp = (m_lp + 64 > 4096) ? 4096 : m_lp + 64;
    else if ((s & PS) != 0 && (s & PA) == 0) m_lp = (m_lp < 64) ? 0 : m_lp - 64;
    // filter step, modulo 6 ring
    if ((s & RF) != 0) m_lf = 0;
    else if ((s & FA) != 0 && (s & FS) == 0) m_lf = (m_lf + 1) % 6;
    else if ((s & FS) != 0 && (s & FA) == 0) m_lf = (m_lf + 5) % 6;
    if (apply) begin
      m_ap = old_lp;
      m_af = old_lf;
    end
    m_upd  = apply;
    m_pend = !apply && mismatch;
  endtask

  // One clock: drive, model the edge, sample 1 time unit after the edge, compare.
  task automatic step(input int s);
    reset             = (s & RST) != 0;
    enable_pixel_add  = (s & PA) != 0;
    enable_pixel_sub  = (s & PS) != 0;
    enable_filter_add = (s & FA) != 0;
    enable_filter_sub = (s & FS) != 0;
    reset_pixel       = (s & RP) != 0;
    reset_filter      = (s & RF) != 0;
    frame_done        = (s & FD) != 0;
    @(posedge clock);
    model_edge(s);
    #1;
    chk("pixel_threshold", 32'(pixel_threshold), 32'(m_ap));
    chk("filter_select", 32'(filter_select), 32'(m_af));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    chk("cfg_update", 32'(cfg_update), 32'(m_upd));
  endtask

  task automatic steps(input int s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  initial begin
    int s;
    // Reset state
    step(RST | PA | FA | FD);
    chk("rst_pixel", 32'(pixel_threshold), 32'd1024);
    chk("rst_filter", 32'(filter_select), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_update", 32'(cfg_update), 32'd0);

    // Three adds then frame_done
    step(PA);
    chk("add1_pending_lag", 32'(cfg_pending), 32'd0);
    step(PA);
    chk("add2_pending", 32'(cfg_pending), 32'd1);
    step(PA);
    chk("add3_hold_pixel", 32'(pixel_threshold), 32'd1024);
    step(FD);
    chk("apply_pixel", 32'(pixel_threshold), 32'd1216);
    chk("apply_update", 32'(cfg_update), 32'd1);
    step(IDLE);
    chk("after_apply_update", 32'(cfg_update), 32'd0);
    chk("after_apply_pending", 32'(cfg_pending), 32'd0);

    // Saturation at the top: 1216 -> 4032 -> 4096
    steps(PA, 44);
    steps(PA, 2);
    step(FD);
    chk("sat_max", 32'(pixel_threshold), 32'd4096);
    step(IDLE);
    // Floor at zero: 4096 -> 64 -> 0
    steps(PS, 63);
    steps(PS, 2);
    step(FD);
    chk("sat_zero", 32'(pixel_threshold), 32'd0);
    step(IDLE);

    // Filter wrap both ways
    steps(FA, 5);
    step(IDLE);
    step(FD);
    chk("filter_5", 32'(filter_select), 32'd5);
    step(FA);
    step(IDLE);
    step(FD);
    chk("filter_wrap_up", 32'(filter_select), 32'd0);
    step(FS);
    step(IDLE);
    step(FD);
    chk("filter_wrap_down", 32'(filter_select), 32'd5);
    step(FA | FS);
    step(IDLE);
    chk("filter_cancel_pending", 32'(cfg_pending), 32'd0);

    // Step coinciding with frame_done stays pending
    step(RST);
    step(PA);
    step(IDLE);
    step(FD | PA);
    chk("coincide_apply", 32'(pixel_threshold), 32'd1088);
    chk("coincide_update", 32'(cfg_update), 32'd1);
    step(IDLE);
    chk("coincide_pending", 32'(cfg_pending), 32'd1);
    step(FD);
    chk("coincide_next", 32'(pixel_threshold), 32'd1152);

    // Add then sub: pending pulse without update; reset_pixel beats add
    step(RST);
    step(PA);
    step(PS);
    chk("addsub_pending_rise", 32'(cfg_pending), 32'd1);
    step(IDLE);
    chk("addsub_pending_fall", 32'(cfg_pending), 32'd0);
    chk("addsub_no_update", 32'(cfg_update), 32'd0);
    step(RP | PA);
    step(IDLE);
    step(FD);
    chk("rstpix_override", 32'(cfg_pending) + 32'(cfg_update), 32'd0);

    // Reset during APPLY with a change still pending
    step(RST);
    step(PA);
    step(IDLE);
    step(FD | PA);
    step(RST);
    chk("midapply_pixel", 32'(pixel_threshold), 32'd1024);
    chk("midapply_update", 32'(cfg_update), 32'd0);
    step(IDLE);
    step(FD);
    chk("midapply_later_update", 32'(cfg_update), 32'd0);
    chk("midapply_later_pixel", 32'(pixel_threshold), 32'd1024);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s = 0;
      if ($urandom_range(0, 99) < 2)  s |= RST;
      if ($urandom_range(0, 3) == 0)  s |= PA;
      if ($urandom_range(0, 3) == 0)  s |= PS;
      if ($urandom_range(0, 3) == 0)  s |= FA;
      if ($urandom_range(0, 3) == 0)  s |= FS;
      if ($urandom_range(0, 31) == 0) s |= RP;
      if ($urandom_range(0, 31) == 0) s |= RF;
      if ($urandom_range(0, 3) == 0)  s |= FD;
      // Bias toward long climbs so both saturation limits get hit
      if (i >= 1000 && i < 1400) s = (s & ~(PS | RP | RST)) | PA;
      if (i >= 1400 && i < 1800) s = (s & ~(PA | RP | RST)) | PS;
      step(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
